// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg -- types and helpers for the instruction fetch unit.
//   qstate_e      : fetch-queue occupancy (EMPTY / ONE / FULL)
//   fetch_entry_t : one queued {pc, inst} pair (64 bits)
//   PC_INC        : sequential fetch stride in bytes
//   align_pc()    : force a byte address onto a word boundary
`include "Core.vh"

package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        Q_EMPTY = `QS_EMPTY,
        Q_ONE   = `QS_ONE,
        Q_FULL  = `QS_FULL
    } qstate_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] PC_INC = `PC_INC;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/Core.vh
// Core.vh -- constants shared by the fetch unit and its bench.
//   IM_ADDR_BIT : width of the instruction-memory word address
//   PC_INC      : byte increment from one fetch to the next
//   QS_*        : encodings of the fetch-queue occupancy states
`ifndef CORE_VH
`define CORE_VH

`define IM_ADDR_BIT 10
`define PC_INC      32'd4

`define QS_EMPTY    2'd0
`define QS_ONE      2'd1
`define QS_FULL     2'd2

`endif

// File: rtl/inst_fetch_unit_queue.sv
// fetch_queue -- two-entry FIFO of {pc, inst} pairs between fetch and decode.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : enqueue one 64-bit entry (ignored when full without pop)
//   pop             : dequeue the head entry (ignored when empty)
//   flush           : discard all entries; overrides push and pop
//   head_data       : current head entry (stable until popped)
//   full, empty     : occupancy flags
`include "Core.vh"

module fetch_queue
    import inst_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [63:0] push_data,
    output logic [63:0] head_data,
    output logic        full,
    output logic        empty
);

    qstate_e     state_q, state_d;
    logic [63:0] entry0_q, entry0_d;   // head
    logic [63:0] entry1_q, entry1_d;   // second slot, valid only when FULL
    logic        push_ok;
    logic        pop_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= Q_EMPTY;
            entry0_q <= '0;
            entry1_q <= '0;
        end else begin
            state_q  <= state_d;
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        // A full queue can still accept a push in the cycle its head leaves.
        push_ok  = push & ((state_q != Q_FULL) | pop);
        pop_ok   = pop & (state_q != Q_EMPTY);

        if (flush) begin
            state_d = Q_EMPTY;
        end else begin
            case (state_q)
                Q_EMPTY: begin
                    if (push_ok) begin
                        entry0_d = push_data;
                        state_d  = Q_ONE;
                    end
                end
                Q_ONE: begin
                    case ({push_ok, pop_ok})
                        2'b11: entry0_d = push_data;   // replace head, stay ONE
                        2'b10: begin
                            entry1_d = push_data;
                            state_d  = Q_FULL;
                        end
                        2'b01: state_d = Q_EMPTY;
                        default: ;
                    endcase
                end
                Q_FULL: begin
                    if (pop_ok) begin
                        entry0_d = entry1_q;           // second slot becomes head
                        if (push_ok) begin
                            entry1_d = push_data;
                        end else begin
                            state_d = Q_ONE;
                        end
                    end
                end
                default: state_d = Q_EMPTY;
            endcase
        end
    end

    assign head_data = entry0_q;
    assign full      = (state_q == Q_FULL);
    assign empty     = (state_q == Q_EMPTY);

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit -- sequential instruction fetch with redirect, halt and a
// two-entry output buffer feeding decode over a valid/ready stream.
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_cnt output.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   im_addr / im_inst          : word address to, and same-cycle data from,
//                                the combinational instruction memory
//   redirect_valid/redirect_pc : branch/jump target from execute (flushes)
//   halt                       : stop issuing new fetches; queue still drains
//   fetch_cnt                  : (FETCH_PERF_CNT_EN only) delivered count
//   out_valid/out_ready        : handshake to decode
//   out_inst/out_pc            : head instruction and its byte address
`include "Core.vh"

module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [`IM_ADDR_BIT-1:0] im_addr,
    input  logic [31:0]             im_inst,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    input  logic                    halt,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]             fetch_cnt,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_inst,
    output logic [31:0]             out_pc
);

    logic [31:0]  pc_q, pc_d;
    logic         pop;
    logic         push;
    logic         q_full;
    logic         q_empty;
    logic [63:0]  head_raw;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign pop  = out_valid & out_ready;
    assign push = ~halt & ~redirect_valid & (~q_full | pop);

    assign push_entry = '{pc: pc_q, inst: im_inst};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (push) begin
            pc_d = pc_q + PC_INC;              // wraps naturally at 2^32
        end
    end

    assign im_addr = pc_q[`IM_ADDR_BIT+1:2];

    // The queue's own flush already beats pop; masking pop here as well keeps
    // the "no pop in a redirect cycle" rule visible at this level.
    fetch_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop & ~redirect_valid),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .head_data (head_raw),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign head_entry = head_raw;
    assign out_valid  = ~q_empty;
    assign out_inst   = head_entry.inst;
    assign out_pc     = head_entry.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (pop && !redirect_valid) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit -- directed scoreboard bench for inst_fetch_unit.
// Stimulus pushes the {pc, inst} pairs it expects decode to receive; a
// negedge monitor pops and compares on every accepted handshake.
`include "Core.vh"

module tb_inst_fetch_unit;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [`IM_ADDR_BIT-1:0] im_addr;
    logic [31:0]             im_inst;
    logic                    redirect_valid;
    logic [31:0]             redirect_pc;
    logic                    halt;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_inst;
    logic [31:0]             out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]             fetch_cnt;
`endif

    logic [31:0] mem [0:(1<<`IM_ADDR_BIT)-1];
    logic [63:0] exp_q [$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign im_inst = mem[im_addr];

    inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .im_addr        (im_addr),
        .im_inst        (im_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt      (fetch_cnt),
`endif
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    // Memory contents: words 0..3 are 0x11,0x22,0x33,0x44, others tagged.
    function automatic logic [31:0] mem_word(input int idx);
        if (idx < 4) return 32'(17 * (idx + 1));
        return 32'hC0DE_0000 | 32'(idx);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end else begin
            $display("[TB] ok   %s = %h", name, got);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(int'(pc[`IM_ADDR_BIT+1:2]))});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one line per accepted transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            logic [63:0] e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL stream_unexpected: got pc %h inst %h, expected no transfer", out_pc, out_inst);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e[63:32] || out_inst !== e[31:0]) begin
                    fails++;
                    $display("FAIL stream: got pc %h inst %h, expected pc %h inst %h",
                             out_pc, out_inst, e[63:32], e[31:0]);
                end else begin
                    $display("[TB] xfer pc %h inst %h", out_pc, out_inst);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << `IM_ADDR_BIT); i++) mem[i] = mem_word(i);
        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;

        // ---- Reset state, then streaming with out_ready high ----
        step(); step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_im_addr", 32'(im_addr), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_fetch_cnt", fetch_cnt, 32'd0);
`endif
        rst = 1'b0;                                        // cycle 0
        for (int i = 0; i < 7; i++) expect_fetch(32'(4 * i));
        for (int n = 1; n <= 8; n++) begin
            step();
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_pc", out_pc, 32'(4 * (n - 1)));
        end
        out_ready = 1'b0;                                  // keep 0x1C queued
        check("stream_first_inst_pc20", 32'(im_addr), 32'h8);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // ---- Asynchronous reset mid-stream at pc 0x20 ----
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_pc", out_pc, 32'd0);
        check("async_rst_im_addr", 32'(im_addr), 32'd0);
        step();
        rst = 1'b0;                                        // cycle 0

        // ---- Back-pressure: out_ready low for 5 cycles ----
        expect_fetch(32'h0); expect_fetch(32'h4);
        step();                                            // c1
        check("bp_c1_pc", out_pc, 32'h0);
        step();                                            // c2: FULL
        check("bp_full_im_addr", 32'(im_addr), 32'h2);
        step(); step(); step();                            // c5
        check("bp_hold_pc", out_pc, 32'h0);
        check("bp_frozen_im_addr", 32'(im_addr), 32'h2);
        out_ready = 1'b1;
        step();                                            // c6
        check("bp_rel_pc4", out_pc, 32'h4);
        step();                                            // c7
        check("bp_rel_pc8", out_pc, 32'h8);
        out_ready = 1'b0;
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // ---- Redirect while FULL ----
        check("redir_pre_im_addr", 32'(im_addr), 32'h4);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        step();                                            // c8
        redirect_valid = 1'b0;
        check("redir_flush_valid", {31'd0, out_valid}, 32'd0);
        check("redir_im_addr", 32'(im_addr), 32'h40);
        step();                                            // c9
        check("redir_out_pc", out_pc, 32'h100);
        check("redir_out_inst", out_inst, mem_word(32'h40));

        // ---- Halt with two entries queued ----
        step();                                            // c10: FULL
        check("halt_full_im_addr", 32'(im_addr), 32'h42);
        expect_fetch(32'h100); expect_fetch(32'h104);
        halt = 1'b1; out_ready = 1'b1;
        step();                                            // c11
        check("halt_drain_pc", out_pc, 32'h104);
        step();                                            // c12
        check("halt_empty_valid", {31'd0, out_valid}, 32'd0);
        check("halt_pc_held", 32'(im_addr), 32'h42);
        step();                                            // c13
        check("halt_still_empty", {31'd0, out_valid}, 32'd0);
        expect_fetch(32'h108);
        halt = 1'b0;
        step();                                            // c14
        check("halt_resume_pc", out_pc, 32'h108);
        step();                                            // c15
        out_ready = 1'b0;
        check("halt_drained", 32'(exp_q.size()), 32'd0);

        // ---- Reset, 10 pops, then redirect (with halt) during a valid pop ----
        rst = 1'b1;
        #1;
        check("rst2_valid", {31'd0, out_valid}, 32'd0);
        step();
        rst = 1'b0; out_ready = 1'b1;                      // cycle 0
        for (int i = 0; i < 10; i++) expect_fetch(32'(4 * i));
        for (int n = 1; n <= 10; n++) step();              // c10
        step();                                            // c11: head 0x28
        check("cnt_pre_redir_pc", out_pc, 32'h28);
        redirect_valid = 1'b1; redirect_pc = 32'h202; halt = 1'b1;
        step();                                            // c12
        redirect_valid = 1'b0; halt = 1'b0;
        check("cnt_redir_valid", {31'd0, out_valid}, 32'd0);
        check("cnt_redir_im_addr", 32'(im_addr), 32'h80);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt_10", fetch_cnt, 32'd10);
`endif
        out_ready = 1'b0;
        step();                                            // c13
        check("cnt_after_redir_pc", out_pc, 32'h200);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
